mixer: RTL and testbench

MIXER -- requirements
Module: mixer

---
 rtl/mixer.sv | 82 ++++++++
 tb/tb_mixer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mixer.sv
// -----------------------------------------------------------------------------
// mixer -- 1-bit sigma-delta RF mixer.
//
// The RF comparator bit is registered (rf_q). That registered bit is fed back
// to the front-end integrator and also selects the sign applied to the
// local-oscillator samples:
//   rf_q = 1 : pass the LO sample through
//   rf_q = 0 : negate it, saturating -2^(W-1) to +(2^(W-1)-1)
// The products are registered. Latency is 1 clock from the LO inputs to the
// outputs and 2 clocks from RFIn to the outputs.
//
// Ports
//   clk          : system clock; all state updates on its rising edge
//   reset        : synchronous, active-high; clears rf_q and both products
//   RFIn         : comparator output of the sigma-delta front end
//   sin_in       : LO sine sample, W-bit signed
//   cos_in       : LO cosine sample, W-bit signed
//   RFOut        : registered RF bit (rf_q), fed back to the RC integrator
//   MixerOutSin  : Q-path product, registered, W-bit signed
//   MixerOutCos  : I-path product, registered, W-bit signed
// -----------------------------------------------------------------------------
module mixer #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RFIn,
  input  logic signed [W-1:0] sin_in,
  input  logic signed [W-1:0] cos_in,
  output logic                RFOut,
  output logic signed [W-1:0] MixerOutSin,
  output logic signed [W-1:0] MixerOutCos
);

  // Apply the sign selected by the RF bit at W+1 bits, so that negating the
  // most negative input cannot wrap. The result is then clipped back to W bits.
  // Only -(-2^(W-1)) can actually overflow.
  function automatic logic signed [W-1:0] mix_sat(
    input logic signed [W-1:0] x,
    input logic                pass
  );
    logic signed [W:0] wide;
    wide = {x[W-1], x};
    if (!pass) begin
      wide = -wide;
    end
    if (wide[W] != wide[W-1]) begin
      mix_sat = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      mix_sat = wide[W-1:0];
    end
  endfunction

  logic                rf_q,  rf_d;
  logic signed [W-1:0] sin_q, sin_d;
  logic signed [W-1:0] cos_q, cos_d;

  // Both paths use the same registered RF bit in the same cycle.
  always_comb begin
    rf_d  = RFIn;
    sin_d = mix_sat(sin_in, rf_q);
    cos_d = mix_sat(cos_in, rf_q);
  end

  // Stage boundary: RF sample and mixer products.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q  <= 1'b0;
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      rf_q  <= rf_d;
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

  assign RFOut       = rf_q;
  assign MixerOutSin = sin_q;
  assign MixerOutCos = cos_q;

endmodule

// File: tb/tb_mixer.sv
module tb_mixer;

  localparam int W    = 8;
  localparam int MAXV = (2 ** (W - 1)) - 1;
  localparam int MINV = -(2 ** (W - 1));

  logic                clk;
  logic                reset;
  logic                RFIn;
  logic signed [W-1:0] sin_in;
  logic signed [W-1:0] cos_in;
  logic                RFOut;
  logic signed [W-1:0] MixerOutSin;
  logic signed [W-1:0] MixerOutCos;

  mixer #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .RFIn       (RFIn),
    .sin_in     (sin_in),
    .cos_in     (cos_in),
    .RFOut      (RFOut),
    .MixerOutSin(MixerOutSin),
    .MixerOutCos(MixerOutCos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit    rf;
    int    s;
    int    c;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 0;

  // Reference model: the RF bit seen by the mixer at an edge is the RFIn that
  // was present at the previous edge, or 0 if that edge was a reset edge (or
  // there was no previous edge).
  bit model_rf = 0;

  function automatic int model_mix(input int v, input bit pass);
    int r;
    r = pass ? v : -v;
    if (r > MAXV) r = MAXV;
    if (r < MINV) r = MINV;
    return r;
  endfunction

  // Drive one clock's worth of inputs and record what the coming edge must yield.
  task automatic cycle(input bit rst, input bit rf, input int s, input int c,
                       input string tag);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    RFIn   = rf;
    sin_in = W'(s);
    cos_in = W'(c);
    e.tag  = tag;
    if (rst) begin
      e.rf = 0; e.s = 0; e.c = 0;
      model_rf = 0;
    end else begin
      e.rf = rf;
      e.s  = model_mix(s, model_rf);
      e.c  = model_mix(c, model_rf);
      model_rf = rf;
    end
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: outputs are valid every clock; compare just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.tag, ".RFOut"},       int'(RFOut),       int'(e.rf));
        check({e.tag, ".MixerOutSin"}, int'(MixerOutSin), e.s);
        check({e.tag, ".MixerOutCos"}, int'(MixerOutCos), e.c);
      end
    end
  end

  function automatic int rand_val();
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) return MINV;
    if (k == 1) return MAXV;
    if (k == 2) return 0;
    return int'($urandom_range(0, 2 ** W - 1)) + MINV;
  endfunction

  initial begin
    reset  = 1'b1;
    RFIn   = 1'b0;
    sin_in = '0;
    cos_in = '0;

    // Reset first, with non-zero inputs to show reset wins.
    cycle(1, 1, 55, -33, "reset0");
    cycle(1, 1, 55, -33, "reset1");

    // Basic pass/negate sequence.
    cycle(0, 0, 0, 80, "s24a");    // first edge after reset: negated LO
    cycle(0, 0, 0, 80, "s24b");    // MixerOutCos = -80
    cycle(0, 1, 0, 80, "s25a");    // RFOut -> 1, cos still -80
    cycle(0, 1, 0, 80, "s25b");    // cos = +80
    cycle(0, 1, 20, 80, "s26");    // sin = 20 one clock later
    cycle(0, 1, 20, 80, "s26b");

    // Saturation on negation, and the most negative value passing unchanged.
    cycle(0, 0, -128, 127, "s27a");
    cycle(0, 0, -128, 127, "s27b"); // sin = +127, cos = -127
    cycle(0, 1, -128, -128, "s27c");
    cycle(0, 1, -128, -128, "pass_min"); // pass: stays -128
    cycle(0, 0, 0, 0, "zero_a");
    cycle(0, 1, 0, 0, "zero_b");

    // Mid-stream reset, then resume with negated LO.
    cycle(0, 1, 40, 60, "pre_rst");
    cycle(1, 1, 40, 60, "s28_rst");
    cycle(0, 1, 40, 60, "s28_resume");
    cycle(0, 1, 40, 60, "s28_pass");

    // RFIn toggling every clock with constant cos.
    for (int i = 0; i < 8; i++) begin
      cycle(0, i[0], 10, 50, "s29");
    end

    // Random stream with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 24) == 0), $urandom_range(0, 1),
            rand_val(), rand_val(), "rand");
    end

    stim_done = 1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
